// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings, FSM state type, write-strobe patterns and ALU operation set.
// Used by rv32i_alu and rv32i_core; optional halt support is enabled by RV32I_CORE_HALT_EN.
package rv32i_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [2:0] F3_SB = 3'd0;
    localparam logic [2:0] F3_SH = 3'd1;
    localparam logic [2:0] F3_SW = 3'd2;

    localparam logic [2:0] WS_NONE = 3'b000;
    localparam logic [2:0] WS_BYTE = 3'b001;
    localparam logic [2:0] WS_HALF = 3'b011;
    localparam logic [2:0] WS_WORD = 3'b111;

    typedef enum logic [1:0] {EXEC, LOAD_WAIT, HALT} state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    // alt is instr[30]; it selects SUB only for register-register ops, SRA for both.
    function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic alt, input logic is_op);
        case (f3)
            F3_ADD_SUB: return (alt && is_op) ? ALU_SUB : ALU_ADD;
            F3_SLL:     return ALU_SLL;
            F3_SLT:     return ALU_SLT;
            F3_SLTU:    return ALU_SLTU;
            F3_XOR:     return ALU_XOR;
            F3_SRL_SRA: return alt ? ALU_SRA : ALU_SRL;
            F3_OR:      return ALU_OR;
            default:    return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_alu.sv
// Combinational 32-bit integer ALU; also supplies the XOR/SLT/SLTU results that drive branch decisions.
// Shift amounts use only the low five bits of operand b.
module rv32i_alu
    import rv32i_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    always_comb begin
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'd0, a < b};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = a + b;
        endcase
    end

endmodule

// File: rtl/rv32i_core.sv
// Single-issue RV32I core: one-cycle execution, two-cycle loads, combinational store strobes.
// Define RV32I_CORE_HALT_EN to make ECALL/EBREAK halt the core and expose the halted output.
module rv32i_core
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] program_counter,
    input  logic [31:0] program_memory_value,
    output logic [31:0] memory_address,
    output logic [31:0] memory_wdata,
    input  logic [31:0] memory_rdata,
    output logic [2:0]  memory_write_sections
`ifdef RV32I_CORE_HALT_EN
    ,
    output logic        halted
`endif
);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] regs [32];

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign instr  = program_memory_value;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    alu_op_t     alu_op;
    logic [31:0] alu_a, alu_b, alu_result;

    // Loads keep computing rs1+imm in LOAD_WAIT; the instruction and rs1 are unchanged there.
    always_comb begin
        alu_op = ALU_ADD;
        alu_a  = rs1_val;
        alu_b  = imm_i;
        case (opcode)
            OPC_OP: begin
                alu_b  = rs2_val;
                alu_op = alu_decode(f3, instr[30], 1'b1);
            end
            OPC_OP_IMM: alu_op = alu_decode(f3, instr[30], 1'b0);
            OPC_STORE:  alu_b = imm_s;
            OPC_BRANCH: begin
                alu_b = rs2_val;
                case (f3[2:1])
                    2'b10:   alu_op = ALU_SLT;
                    2'b11:   alu_op = ALU_SLTU;
                    default: alu_op = ALU_XOR;
                endcase
            end
            OPC_LUI: begin
                alu_a = 32'd0;
                alu_b = imm_u;
            end
            OPC_AUIPC: begin
                alu_a = pc;
                alu_b = imm_u;
            end
            OPC_JAL, OPC_JALR: begin
                alu_a = pc;
                alu_b = 32'd4;
            end
            default: ;
        endcase
    end

    rv32i_alu u_alu (
        .op     (alu_op),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_result)
    );

    logic        taken;
    logic [31:0] pc_plus4, next_pc, jalr_target, load_value;
    logic        exec_writes;

    always_comb begin
        case (f3)
            F3_BEQ:           taken = (alu_result == 32'd0);
            F3_BNE:           taken = (alu_result != 32'd0);
            F3_BLT, F3_BLTU:  taken = alu_result[0];
            F3_BGE, F3_BGEU:  taken = ~alu_result[0];
            default:          taken = 1'b0;
        endcase
    end

    assign pc_plus4    = pc + 32'd4;
    assign jalr_target = (rs1_val + imm_i) & ~32'd1;

    always_comb begin
        next_pc = pc_plus4;
        case (opcode)
            OPC_BRANCH: if (taken) next_pc = pc + imm_b;
            OPC_JAL:    next_pc = pc + imm_j;
            OPC_JALR:   next_pc = jalr_target;
            default: ;
        endcase
    end

    always_comb begin
        case (f3)
            F3_LB:   load_value = {{24{memory_rdata[7]}}, memory_rdata[7:0]};
            F3_LH:   load_value = {{16{memory_rdata[15]}}, memory_rdata[15:0]};
            F3_LBU:  load_value = {24'd0, memory_rdata[7:0]};
            F3_LHU:  load_value = {16'd0, memory_rdata[15:0]};
            default: load_value = memory_rdata;
        endcase
    end

    always_comb begin
        case (opcode)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: exec_writes = 1'b1;
            default: exec_writes = 1'b0;
        endcase
    end

`ifdef RV32I_CORE_HALT_EN
    logic is_halt;
    assign is_halt = (opcode == OPC_SYSTEM) && (f3 == 3'd0);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= EXEC;
            pc    <= RESET_PC;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else begin
            case (state)
                EXEC: begin
                    if (opcode == OPC_LOAD) begin
                        state <= LOAD_WAIT;
`ifdef RV32I_CORE_HALT_EN
                    end else if (is_halt) begin
                        state <= HALT;
`endif
                    end else begin
                        pc <= next_pc;
                        if (exec_writes && rd != 5'd0) regs[rd] <= alu_result;
                    end
                end
                LOAD_WAIT: begin
                    if (rd != 5'd0) regs[rd] <= load_value;
                    pc    <= pc_plus4;
                    state <= EXEC;
                end
                default: ;
            endcase
        end
    end

    assign program_counter = pc;
    assign memory_address  = reset_n ? alu_result : 32'd0;
    assign memory_wdata    = reset_n ? rs2_val : 32'd0;

    always_comb begin
        memory_write_sections = WS_NONE;
        if (reset_n && state == EXEC && opcode == OPC_STORE) begin
            case (f3)
                F3_SB:   memory_write_sections = WS_BYTE;
                F3_SH:   memory_write_sections = WS_HALF;
                F3_SW:   memory_write_sections = WS_WORD;
                default: memory_write_sections = WS_NONE;
            endcase
        end
    end

`ifdef RV32I_CORE_HALT_EN
    assign halted = (state == HALT);
`endif

endmodule

// File: tb/tb_rv32i_core.sv
// Self-checking bench for rv32i_core: directed plus random programs run on an instruction-level
// reference model whose per-cycle expectations are queued and checked by an independent monitor.
module tb_rv32i_core;

    localparam int          ROM_WORDS = 512;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [6:0]  O_LOAD = 7'b0000011, O_STORE = 7'b0100011, O_OP = 7'b0110011,
                            O_OPI = 7'b0010011, O_BR = 7'b1100011, O_JAL = 7'b1101111,
                            O_JALR = 7'b1100111, O_LUI = 7'b0110111, O_AUIPC = 7'b0010111,
                            O_SYS = 7'b1110011, O_FENCE = 7'b0001111;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] program_counter, program_memory_value, memory_address, memory_wdata;
    logic [31:0] memory_rdata;
    logic [2:0]  memory_write_sections;
`ifdef RV32I_CORE_HALT_EN
    logic        halted;
`endif

    logic [31:0] rom [ROM_WORDS];
    logic [7:0]  dmem [256];
    logic [7:0]  ref_mem [256];
    logic [31:0] ref_x [32];

    typedef struct {
        logic [31:0] pc;
        bit          chk_addr;
        logic [31:0] addr;
        logic [2:0]  ws;
        logic [31:0] wdata;
    } rec_t;

    rec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_go = 1'b0;
    bit   mon_done = 1'b0;
    int   p = 0;

    always #5 clock = ~clock;

    rv32i_core #(.RESET_PC(32'h0000_0000)) dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .program_counter       (program_counter),
        .program_memory_value  (program_memory_value),
        .memory_address        (memory_address),
        .memory_wdata          (memory_wdata),
        .memory_rdata          (memory_rdata),
        .memory_write_sections (memory_write_sections)
`ifdef RV32I_CORE_HALT_EN
        ,
        .halted                (halted)
`endif
    );

    always_comb begin
        if (program_counter < 32'd2048) program_memory_value = rom[program_counter[10:2]];
        else                            program_memory_value = NOP;
    end

    // Byte-wide data RAM, 256 bytes wrapping; read data appears the cycle after the address.
    always @(posedge clock) begin
        memory_rdata <= {dmem[memory_address[7:0] + 8'd3], dmem[memory_address[7:0] + 8'd2],
                         dmem[memory_address[7:0] + 8'd1], dmem[memory_address[7:0]]};
        if (memory_write_sections[0]) dmem[memory_address[7:0]] <= memory_wdata[7:0];
        if (memory_write_sections[1]) dmem[memory_address[7:0] + 8'd1] <= memory_wdata[15:8];
        if (memory_write_sections[2]) begin
            dmem[memory_address[7:0] + 8'd2] <= memory_wdata[23:16];
            dmem[memory_address[7:0] + 8'd3] <= memory_wdata[31:24];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fetch(input logic [31:0] a);
        if (a < 32'd2048) return rom[a[10:2]];
        return NOP;
    endfunction

    function automatic logic [31:0] i_t(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        logic [31:0] v = imm;
        return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction
    function automatic logic [31:0] r_t(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), O_OP};
    endfunction
    function automatic logic [31:0] s_t(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], O_STORE};
    endfunction
    function automatic logic [31:0] b_t(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], O_BR};
    endfunction
    function automatic logic [31:0] u_t(input logic [31:0] v, input int rd, input logic [6:0] op);
        return {v[31:12], 5'(rd), op};
    endfunction
    function automatic logic [31:0] j_t(input int imm, input int rd);
        logic [31:0] v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), O_JAL};
    endfunction

    task automatic emit(input logic [31:0] ins);
        rom[p] = ins;
        p++;
    endtask

    task automatic push(input logic [31:0] pc, input bit ca, input logic [31:0] addr,
                        input logic [2:0] ws, input logic [31:0] wd);
        rec_t r;
        r.pc = pc; r.chk_addr = ca; r.addr = addr; r.ws = ws; r.wdata = wd;
        exp_q.push_back(r);
    endtask

    // Instruction-set model: executes the program and records what each DUT cycle must show.
    task automatic run_ref(input logic [31:0] end_pc);
        logic [31:0] pc, ins, a, b, res, ea, word, iimm, simm, bimm, jimm, npc;
        logic [7:0]  ix;
        logic [2:0]  f3;
        int          rd, guard;
        bit          wr, tk;
        pc = 32'd0;
        guard = 0;
        for (int i = 0; i < 32; i++) ref_x[i] = 32'd0;
        while (pc < end_pc && guard < 5000) begin
            guard++;
            ins  = fetch(pc);
            f3   = ins[14:12];
            rd   = int'(ins[11:7]);
            a    = ref_x[ins[19:15]];
            b    = ref_x[ins[24:20]];
            iimm = 32'($signed(ins) >>> 20);
            simm = {iimm[31:5], ins[11:7]};
            bimm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            jimm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            npc  = pc + 32'd4;
            wr   = 1'b0;
            res  = 32'd0;
            case (ins[6:0])
                O_OP, O_OPI: begin
                    if (ins[6:0] == O_OPI) b = iimm;
                    case (f3)
                        3'd0: res = (ins[6:0] == O_OP && ins[30]) ? a - b : a + b;
                        3'd1: res = a << b[4:0];
                        3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        3'd3: res = (a < b) ? 32'd1 : 32'd0;
                        3'd4: res = a ^ b;
                        3'd5: res = ins[30] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
                        3'd6: res = a | b;
                        default: res = a & b;
                    endcase
                    wr = 1'b1;
                    push(pc, 1'b1, res, 3'b000, 32'd0);
                end
                O_LUI:   begin res = {ins[31:12], 12'd0}; wr = 1'b1; push(pc, 1'b0, 0, 3'b000, 0); end
                O_AUIPC: begin res = pc + {ins[31:12], 12'd0}; wr = 1'b1; push(pc, 1'b0, 0, 3'b000, 0); end
                O_JAL:   begin res = pc + 32'd4; npc = pc + jimm; wr = 1'b1; push(pc, 1'b0, 0, 3'b000, 0); end
                O_JALR:  begin res = pc + 32'd4; npc = (a + iimm) & 32'hFFFF_FFFE; wr = 1'b1; push(pc, 1'b0, 0, 3'b000, 0); end
                O_BR: begin
                    case (f3)
                        3'd0: tk = (a == b);
                        3'd1: tk = (a != b);
                        3'd4: tk = $signed(a) < $signed(b);
                        3'd5: tk = $signed(a) >= $signed(b);
                        3'd6: tk = a < b;
                        3'd7: tk = a >= b;
                        default: tk = 1'b0;
                    endcase
                    if (tk) npc = pc + bimm;
                    push(pc, 1'b0, 0, 3'b000, 0);
                end
                O_LOAD: begin
                    ea = a + iimm;
                    ix = ea[7:0];
                    word = {ref_mem[ix + 8'd3], ref_mem[ix + 8'd2], ref_mem[ix + 8'd1], ref_mem[ix]};
                    case (f3)
                        3'd0: res = 32'($signed(word[7:0]));
                        3'd1: res = 32'($signed(word[15:0]));
                        3'd4: res = {24'd0, word[7:0]};
                        3'd5: res = {16'd0, word[15:0]};
                        default: res = word;
                    endcase
                    wr = 1'b1;
                    push(pc, 1'b1, ea, 3'b000, 0);
                    push(pc, 1'b1, ea, 3'b000, 0);
                end
                O_STORE: begin
                    ea = a + simm;
                    ix = ea[7:0];
                    ref_mem[ix] = b[7:0];
                    if (f3 != 3'd0) ref_mem[ix + 8'd1] = b[15:8];
                    if (f3 == 3'd2) begin
                        ref_mem[ix + 8'd2] = b[23:16];
                        ref_mem[ix + 8'd3] = b[31:24];
                    end
                    push(pc, 1'b1, ea, (f3 == 3'd0) ? 3'b001 : (f3 == 3'd1) ? 3'b011 : 3'b111, b);
                end
                default: push(pc, 1'b0, 0, 3'b000, 0);
            endcase
            if (wr && rd != 0) ref_x[rd] = res;
            pc = npc;
        end
    endtask

    task automatic build_program(output logic [31:0] end_pc);
        int tgt, k, f3, rs1, rs2, rd, alt;
        for (int i = 0; i < ROM_WORDS; i++) rom[i] = NOP;
        p = 0;
        emit(NOP); emit(NOP); emit(NOP);
        emit(i_t(-1, 0, 0, 1, O_OPI));              // x1 = -1
        emit(i_t(28, 1, 5, 2, O_OPI));              // SRLI x2 -> 0xF
        emit(i_t(32'h400 + 28, 1, 5, 3, O_OPI));    // SRAI x3 -> -1
        emit(r_t(0, 1, 0, 3, 4));                   // SLTU x4,x0,x1 -> 1
        emit(r_t(0, 1, 0, 2, 5));                   // SLT  x5,x0,x1 -> 0
        emit(u_t(32'h1234_5000, 6, O_LUI));
        emit(i_t(32'h678, 6, 0, 6, O_OPI));
        emit(s_t(16, 6, 0, 2));                     // SW x6,16(x0)
        emit(s_t(20, 6, 0, 0));                     // SB x6,20(x0)
        emit(s_t(32, 2, 0, 2)); emit(s_t(33, 3, 0, 2)); emit(s_t(34, 4, 0, 2)); emit(s_t(35, 5, 0, 2));
        emit(i_t(-8, 0, 0, 8, O_OPI));
        emit(s_t(16, 8, 0, 0));                     // byte 16 = 0xF8
        emit(i_t(16, 0, 0, 7, O_LOAD));             // LB x7 -> 0xFFFFFFF8
        emit(s_t(36, 7, 0, 2));
        emit(i_t(5, 1, 0, 0, O_OPI));               // write to x0
        emit(s_t(40, 0, 0, 2));
        emit(b_t(8, 0, 0, 0));                      // BEQ taken
        emit(i_t(1, 0, 0, 9, O_OPI));
        emit(b_t(8, 0, 0, 1));                      // BNE not taken
        emit(i_t(1, 0, 0, 10, O_OPI));
        emit(b_t(8, 1, 10, 6));                     // BLTU 1 < 0xFFFFFFFF taken
        emit(NOP);
        emit(b_t(8, 1, 10, 4));                     // BLT 1 < -1 not taken
        emit(s_t(44, 10, 0, 2));
        emit(i_t(2, 0, 0, 13, O_OPI));
        emit(i_t(-1, 13, 0, 13, O_OPI));
        emit(b_t(-4, 0, 13, 1));                    // backward loop
        emit(j_t(8, 11));
        emit(NOP);
        emit(s_t(48, 11, 0, 2));
        tgt = (p + 3) * 4;
        emit(i_t(tgt, 0, 0, 12, O_OPI));
        emit(i_t(1, 12, 0, 12, O_JALR));            // rd == rs1, odd offset
        emit(NOP);
        emit(s_t(52, 12, 0, 2));
        for (int r = 1; r < 16; r++) begin
            emit(u_t($urandom, r, O_LUI));
            emit(i_t(int'($urandom_range(0, 4095)), r, 0, r, O_OPI));
        end
        for (int n = 0; n < 160; n++) begin
            k   = int'($urandom_range(0, 9));
            f3  = int'($urandom_range(0, 7));
            rs1 = int'($urandom_range(0, 15));
            rs2 = int'($urandom_range(0, 15));
            rd  = int'($urandom_range(0, 15));
            alt = int'($urandom_range(0, 1));
            case (k)
                0, 1: emit(r_t((alt == 1 && (f3 == 0 || f3 == 5)) ? 32 : 0, rs2, rs1, f3, rd));
                2, 3: begin
                    if (f3 == 1)      emit(i_t(rs2, rs1, 1, rd, O_OPI));
                    else if (f3 == 5) emit(i_t(alt * 1024 + int'($urandom_range(0, 31)), rs1, 5, rd, O_OPI));
                    else              emit(i_t(int'($urandom_range(0, 4095)), rs1, f3, rd, O_OPI));
                end
                4: emit(u_t($urandom, rd, alt == 1 ? O_LUI : O_AUIPC));
                5: emit(s_t(int'($urandom_range(0, 4095)), rs2, rs1, f3 % 3));
                6: emit(i_t(int'($urandom_range(0, 4095)), rs1, (f3 == 3 || f3 > 5) ? 2 : f3, rd, O_LOAD));
                7: emit(b_t(alt == 1 ? 12 : 8, rs2, rs1, (f3 == 2 || f3 == 3) ? 0 : f3));
                8: begin
`ifdef RV32I_CORE_HALT_EN
                    emit({25'd0, O_FENCE});
`else
                    emit(alt == 1 ? {12'd1, 13'd0, O_SYS} : {25'd0, O_SYS});
`endif
                end
                default: emit(i_t(int'($urandom_range(0, 255)), 0, 2, rd, O_LOAD));
            endcase
        end
        end_pc = 32'(p * 4);
    endtask

    initial begin : monitor
        rec_t r;
        int   cyc;
        wait (mon_go);
        #1;
        cyc = 0;
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            $display("cyc %0d pc=%08h ws=%03b addr=%08h wdata=%08h", cyc, program_counter,
                     memory_write_sections, memory_address, memory_wdata);
            chk($sformatf("pc[%0d]", cyc), program_counter, r.pc);
            chk($sformatf("ws[%0d]", cyc), {29'd0, memory_write_sections}, {29'd0, r.ws});
            if (r.chk_addr) chk($sformatf("addr[%0d]", cyc), memory_address, r.addr);
            if (r.ws != 3'b000) chk($sformatf("wdata[%0d]", cyc), memory_wdata, r.wdata);
            cyc++;
            @(negedge clock);
            #1;
        end
        mon_done = 1'b1;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] end_pc;
        reset_n = 1'b0;
        for (int i = 0; i < 256; i++) begin
            dmem[i]    = 8'($urandom);
            ref_mem[i] = dmem[i];
        end
        build_program(end_pc);
        run_ref(end_pc);
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_pc", program_counter, 32'd0);
        chk("reset_ws", {29'd0, memory_write_sections}, 32'd0);
        chk("reset_addr", memory_address, 32'd0);
        chk("reset_wdata", memory_wdata, 32'd0);
        reset_n = 1'b1;
        mon_go  = 1'b1;
        wait (mon_done);

        // Reset in the middle of LOAD_WAIT must abandon the load and restore the PC at once.
        @(negedge clock);
        reset_n = 1'b0;
        rom[2] = i_t(0, 0, 2, 7, O_LOAD);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("load_wait_pc_hold", program_counter, 32'd8);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_pc", program_counter, 32'd0);
        chk("async_reset_ws", {29'd0, memory_write_sections}, 32'd0);
        chk("async_reset_addr", memory_address, 32'd0);

        rom[2] = {25'd0, O_SYS};
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        chk("ecall_pc", program_counter, 32'd8);
`ifdef RV32I_CORE_HALT_EN
        chk("ecall_not_yet_halted", {31'd0, halted}, 32'd0);
        repeat (2) @(negedge clock);
        chk("halt_pc_frozen", program_counter, 32'd8);
        chk("halted_flag", {31'd0, halted}, 32'd1);
        chk("halt_ws", {29'd0, memory_write_sections}, 32'd0);
`else
        @(negedge clock);
        chk("ecall_is_nop", program_counter, 32'd12);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
